ram_scan_display: RTL and testbench
===================================

# ram_scan_display

Autonomous read-side companion for the 16x8 synchronous RAM used in the lab memory experiments. It sweeps the RAM address space, issues one read per address, captures the returned byte, and drives two active-low hex 7-segment digits, stepping automatically after a dwell period or on a manual step pulse. It sits between a RAM read port (1-cycle read latency) and the board's segment displays.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; the sweep covers 0 .. 2^ADDR_W-1.
- DATA_W, 8, RAM data width; fixed at 8 (two hex digits).
- DWELL, 50_000_000, HOLD-state cycles per address in auto mode; minimum 1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  scan enable.
- manual  in  1  1 = advance only on step, 0 = advance after DWELL.
- step  in  1  single-cycle advance request; already debounced and synchronous to clk.
- ram_addr  out  ADDR_W  registered read address to the RAM.
- ram_rd  out  1  read strobe, high for exactly one cycle per read.
- ram_q  in  DATA_W  RAM read data, valid the cycle after the ram_rd cycle.
- seg_hi  out  7  active-low {g,f,e,d,c,b,a} for ram_q[7:4].
- seg_lo  out  7  active-low segments for ram_q[3:0].
- valid  out  1  high while the segments show a captured word.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, HOLD.
- IDLE: ram_rd = 0. Moves to ISSUE when en = 1.
- ISSUE: ram_rd = 1 with ram_addr stable. Always moves to WAIT.
- WAIT: ram_rd = 0. RAM output settles. Always moves to CAPTURE.
- CAPTURE: registers ram_q, decodes both nibbles into seg_hi/seg_lo, sets valid = 1, clears the dwell counter, then moves to HOLD.
- HOLD, auto mode: the dwell counter counts 0..DWELL-1. At terminal count, ram_addr increments and the FSM moves to ISSUE.
- HOLD, manual mode: waits for step = 1, then ram_addr increments and the FSM moves to ISSUE.
- Address wrap: ram_addr increments modulo 2^ADDR_W, so 15 goes to 0 with no pause.
- step outside HOLD is ignored. step in auto mode is ignored.
- manual toggling during HOLD takes effect on the next cycle. The dwell counter is not cleared by the toggle.
- en = 0 in any state forces IDLE on the next edge. ram_rd is 0 in IDLE. ram_addr, segments and valid keep their last values.
- Re-enabling re-reads the current ram_addr; it does not advance.
- Hex decode (active-low gfedcba):
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000
  - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
  - 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011
  - C → 1000110, d → 0100001, E → 0000110, F → 0001110
- Segment outputs are registered. No combinational path exists from ram_q to seg_*.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, ram_addr = 0, ram_rd = 0, seg_hi = seg_lo = 7'b1111111 (blank), valid = 0, dwell counter = 0.
- Read latency: with ISSUE at cycle N, ram_q is sampled at the end of cycle N+2 (CAPTURE). Segments and valid update at the edge ending cycle N+2.
- Auto period per address: 3 + DWELL cycles. With DWELL = 1 this is 4 cycles.
- Manual: a step seen in HOLD at cycle M gives ISSUE at M+1, and the new digits show after the edge ending cycle M+3.
- rst_n asserted mid-read (ISSUE/WAIT/CAPTURE) aborts the read. Nothing is captured and all outputs take their reset values.
- rst_n release is synchronised internally with a 2-flop release synchroniser before the FSM leaves IDLE.

## Configuration
- Macro RAM_SCAN_ADDR_SEG_EN.
- Defined: adds output seg_addr (7 bits, active-low), which shows the hex digit of ram_addr. It updates in the same cycle as seg_hi/seg_lo and is blank (1111111) at reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset release, en = 1, auto, DWELL = 1, RAM preloaded with mem[k] = 8'hF0 + k:
  - reads addr 0,1,2,… every 4 cycles.
  - addr 0: seg_hi = 0001110 (F), seg_lo = 1000000 (0).
  - addr 5: seg_lo = 0010010 (5).
- Wrap: run 17 reads. Address 15 is followed by address 0, and the 17th capture shows F0 again.
- Manual mode, DWELL = 1000:
  - no advance in 2000 cycles.
  - step pulse in HOLD advances exactly one address, seen 3 cycles after the step cycle.
  - step during WAIT is ignored.
- en dropped during WAIT at addr 3:
  - FSM goes to IDLE, ram_rd = 0, segments hold the addr-2 value.
  - re-enable re-reads addr 3.
- rst_n asserted during CAPTURE at addr 7: segments go to 1111111, valid = 0, ram_addr = 0 immediately (asynchronous).
- With RAM_SCAN_ADDR_SEG_EN defined: seg_addr shows 0100001 (d) while the addr-13 word is displayed.

Source files
------------

// File: rtl/ram_scan_display.sv
// ram_scan_display
//   Read-side scanner for a small synchronous RAM (1-cycle read latency).
//   Sweeps addresses 0 .. 2^ADDR_W-1, issues one read per address, captures
//   the returned byte and shows it on two active-low hex 7-segment digits.
//   It advances either after DWELL hold cycles (auto) or on a step pulse
//   (manual).
//
//   Optional feature macro: RAM_SCAN_ADDR_SEG_EN
//     When defined, adds seg_addr, an active-low digit showing the address
//     of the displayed word.
//
// Ports
//   clk       in   clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   scan enable; low forces IDLE, display is held
//   manual    in   1 = advance on step only, 0 = advance after DWELL cycles
//   step      in   single-cycle advance request (debounced, synchronous)
//   ram_addr  out  registered RAM read address
//   ram_rd    out  read strobe, one cycle per read
//   ram_q     in   RAM read data, valid the cycle after ram_rd
//   seg_hi    out  active-low {g,f,e,d,c,b,a} for ram_q[7:4]
//   seg_lo    out  active-low {g,f,e,d,c,b,a} for ram_q[3:0]
//   seg_addr  out  (RAM_SCAN_ADDR_SEG_EN only) active-low digit of the address
//   valid     out  high while the segments show a captured word
module ram_scan_display #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DWELL  = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              manual,
  input  logic              step,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_q,
  output logic [6:0]        seg_hi,
  output logic [6:0]        seg_lo,
`ifdef RAM_SCAN_ADDR_SEG_EN
  output logic [6:0]        seg_addr,
`endif
  output logic              valid
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t           state;
  state_t           next;
  logic [1:0]       rst_sync;
  logic             run_ok;
  logic             advance;
  logic [CNT_W-1:0] dwell_cnt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Reset asserts asynchronously but is released through two flops; the
  // FSM stays in IDLE until the release has propagated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run_ok = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next    = state;
    ram_rd  = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE:    if (run_ok) next = ISSUE;
      ISSUE: begin
        ram_rd = 1'b1;
        next   = WAIT;
      end
      WAIT:    next = CAPTURE;
      CAPTURE: next = HOLD;
      HOLD: begin
        advance = manual ? step : (dwell_cnt >= LAST);
        if (advance) next = ISSUE;
      end
      default: next = IDLE;
    endcase
    if (!en) next = IDLE;
  end

  // Datapath only acts while enabled, so dropping en mid-read aborts the
  // capture and leaves address/display untouched. The dwell counter only
  // runs in auto mode and is not cleared by a mode toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      seg_hi    <= '1;
      seg_lo    <= '1;
      valid     <= 1'b0;
      dwell_cnt <= '0;
`ifdef RAM_SCAN_ADDR_SEG_EN
      seg_addr  <= '1;
`endif
    end else if (en) begin
      if (state == CAPTURE) begin
        seg_hi    <= hex7(ram_q[7:4]);
        seg_lo    <= hex7(ram_q[3:0]);
        valid     <= 1'b1;
        dwell_cnt <= '0;
`ifdef RAM_SCAN_ADDR_SEG_EN
        seg_addr  <= hex7(4'(ram_addr));
`endif
      end else if (state == HOLD) begin
        if (advance)      ram_addr  <= ram_addr + ADDR_W'(1);
        else if (!manual) dwell_cnt <= dwell_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_scan_display.sv
// tb_ram_scan_display
//   Self-checking bench for ram_scan_display (ADDR_W=4, DATA_W=8, DWELL=1).
//   A behavioural model tracks the cycles since the last read was issued,
//   the current address and the displayed word; a compare process checks
//   every DUT output against it on each falling edge. Directed phases pin
//   literal values, then a randomized phase drives en/manual/step.
module tb_ram_scan_display;

  localparam int DW = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       manual = 1'b0;
  logic       step = 1'b0;
  logic [3:0] ram_addr;
  logic       ram_rd;
  logic [7:0] ram_q = 8'h00;
  logic [6:0] seg_hi;
  logic [6:0] seg_lo;
  logic       valid;
`ifdef RAM_SCAN_ADDR_SEG_EN
  logic [6:0] seg_addr;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [16];

  // model: m_ph = -1 idle, 0 read issued, 1 settling, 2 capturing, 3 holding
  int         m_sync = 0;
  int         m_ph = -1;
  int         m_addr = 0;
  int         m_dwell = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_word = 8'h00;
  int         m_saddr = 0;
  int         m_caps = 0;

  ram_scan_display #(
    .ADDR_W(4),
    .DATA_W(8),
    .DWELL (DW)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .manual  (manual),
    .step    (step),
    .ram_addr(ram_addr),
    .ram_rd  (ram_rd),
    .ram_q   (ram_q),
    .seg_hi  (seg_hi),
    .seg_lo  (seg_lo),
`ifdef RAM_SCAN_ADDR_SEG_EN
    .seg_addr(seg_addr),
`endif
    .valid   (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM, one cycle read latency
  always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

  function automatic logic [6:0] hexseg(input int n);
    case (n % 16)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;
      14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync  <= 0;
      m_ph    <= -1;
      m_addr  <= 0;
      m_dwell <= 0;
      m_valid <= 1'b0;
      m_word  <= 8'h00;
      m_saddr <= 0;
    end else begin
      m_sync <= (m_sync < 2) ? m_sync + 1 : 2;
      if (!en) m_ph <= -1;
      else if (m_ph == -1) begin
        if (m_sync == 2) m_ph <= 0;
      end else if (m_ph < 2) m_ph <= m_ph + 1;
      else if (m_ph == 2) begin
        m_ph    <= 3;
        m_valid <= 1'b1;
        m_word  <= mem[m_addr];
        m_saddr <= m_addr;
        m_dwell <= 0;
        m_caps  <= m_caps + 1;
      end else begin
        if (manual ? step : (m_dwell >= DW - 1)) begin
          m_addr <= (m_addr + 1) % 16;
          m_ph   <= 0;
        end else if (!manual) m_dwell <= m_dwell + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 1) begin
      chk("addr", ram_addr, m_addr);
      chk("rd", ram_rd, (m_ph == 0));
      chk("valid", valid, m_valid);
      chk("seg_hi", seg_hi, m_valid ? hexseg(m_word[7:4]) : 7'h7F);
      chk("seg_lo", seg_lo, m_valid ? hexseg(m_word[3:0]) : 7'h7F);
`ifdef RAM_SCAN_ADDR_SEG_EN
      chk("seg_addr", seg_addr, m_valid ? hexseg(m_saddr) : 7'h7F);
`endif
    end
  end

  task automatic wait_caps(input int n);
    int k = 0;
    while (m_caps < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("wait_caps_timeout", (m_caps >= n), 1);
  endtask

  task automatic step_once();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2, t3;
    for (int k = 0; k < 16; k++) mem[k] = 8'hF0 + 8'(k);
    repeat (3) @(negedge clk);
    chk("rst_addr", ram_addr, 0);
    chk("rst_seg_hi", seg_hi, 7'b1111111);
    chk("rst_seg_lo", seg_lo, 7'b1111111);
    chk("rst_valid", valid, 0);
    chk("rst_rd", ram_rd, 0);

    // auto mode sweep
    en = 1'b1;
    rst_n = 1'b1;
    wait_caps(1);
    chk("addr0_hi", seg_hi, 7'b0001110);
    chk("addr0_lo", seg_lo, 7'b1000000);
    wait_caps(2);
    t2 = cyc;
    wait_caps(3);
    t3 = cyc;
    chk("auto_period", t3 - t2, 4);
    wait_caps(6);
    chk("addr5_lo", seg_lo, 7'b0010010);
    wait_caps(14);
`ifdef RAM_SCAN_ADDR_SEG_EN
    chk("addr13_seg_addr", seg_addr, 7'b0100001);
`endif
    chk("addr13_lo", seg_lo, 7'b0100001);
    wait_caps(17);
    chk("wrap_hi", seg_hi, 7'b0001110);
    chk("wrap_lo", seg_lo, 7'b1000000);
    chk("wrap_addr", ram_addr, 0);

    // manual mode: no advance without step
    manual = 1'b1;
    repeat (2000) @(negedge clk);
    chk("manual_hold_addr", ram_addr, 0);
    chk("manual_hold_lo", seg_lo, 7'b1000000);

    // step in HOLD advances once; step during WAIT is ignored
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_issue_rd", ram_rd, 1);
    chk("step_issue_addr", ram_addr, 1);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_pre_lo", seg_lo, 7'b1000000);
    @(negedge clk);
    chk("step_post_lo", seg_lo, 7'b1111001);
    chk("step_post_addr", ram_addr, 1);
    repeat (20) @(negedge clk);
    chk("step_wait_ignored", ram_addr, 1);

    // en dropped during WAIT at address 3
    step_once();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("endrop_rd", ram_rd, 0);
    chk("endrop_addr", ram_addr, 3);
    chk("endrop_hi", seg_hi, 7'b0001110);
    chk("endrop_lo", seg_lo, 7'b0100100);
    repeat (5) @(negedge clk);
    chk("endrop_idle_rd", ram_rd, 0);
    en = 1'b1;
    @(negedge clk);
    chk("reen_rd", ram_rd, 1);
    chk("reen_addr", ram_addr, 3);
    repeat (3) @(negedge clk);
    chk("reen_lo", seg_lo, 7'b0110000);

    // reset asserted during CAPTURE at address 7
    repeat (3) step_once();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_addr", ram_addr, 7);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_hi", seg_hi, 7'b1111111);
    chk("midrst_lo", seg_lo, 7'b1111111);
    chk("midrst_valid", valid, 0);
    chk("midrst_addr", ram_addr, 0);
    repeat (2) @(negedge clk);

    // randomized phase with random RAM contents
    for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
    manual = 1'b0;
    en = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 63) == 0) manual = ~manual;
      step = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
